mips_stage_mem_mc: RTL and testbench
====================================

Name: mips_stage_mem_mc

Overview:
Parametrised successor to the MIPS pipeline memory stage. It adds a data memory with configurable access latency, byte/halfword/word sizing with sign or zero extension, and byte-enabled stores. It also adds valid/ready handshakes on both sides so the stage can stall the pipeline, plus alignment fault detection. It sits between the EX/MEM and MEM/WB pipeline registers and drives the MEM/WB register itself.

Parameters:
ADDR_L, 64, data memory depth in 32-bit words (power of two, >= 2)
ADDR_W, log2(ADDR_L), word-index width
LATENCY, 1, cycles from accepting a load/store to its result on the output (1..4)
WORD_W, 32, datapath width (fixed at 32; byte-lane logic depends on it)

Ports:
clock  input  1  stage clock
reset  input  1  synchronous active-high reset
in_valid  input  1  EX/MEM entry presented
in_ready  output  1  stage accepts an entry this cycle
in_instr  input  32  instruction word
in_pc  input  32  PC of instruction
in_alu  input  32  ALU result / effective byte address
in_store  input  32  store data (register port 2)
in_regdst  input  5  destination register
in_regwrite  input  1  writes a register
in_memread  input  1  load
in_memwrite  input  1  store (memread and memwrite both 1: treated as store)
in_memop  input  3  [1:0] size 00=byte 01=half 10=word; [2]=zero-extend
out_valid  output  1  MEM/WB entry valid
out_ready  input  1  downstream consumes entry
out_instr  output  32  passed through
out_pc  output  32  passed through
out_alu  output  32  passed through
out_memout  output  32  extended load data; 0 for non-loads
out_regdst  output  5  passed through
out_regwrite  output  1  in_regwrite, forced 0 on fault
out_fault  output  1  misaligned access
busy  output  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE, counter=0, out_valid=0, all out_* data=0, out_fault=0. Memory contents are not reset. Reset mid-ACCESS abandons the operation; a pending store whose write edge has not occurred is not written.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept on in_valid && in_ready.
- FSM IDLE -> ACCESS -> IDLE:
  - Non-memory op, faulting op, or LATENCY==1: the result registers on the accept edge. out_valid=1 the next cycle; state stays IDLE.
  - Memory op with LATENCY>1: latch all inputs, enter ACCESS, counter=LATENCY-1, decrement each cycle. At counter==1 the result registers, out_valid rises, and the FSM returns to IDLE. Total: out_valid at accept+LATENCY cycles.
- out_valid stays high with data stable until out_ready is high. Clear on out_ready unless a new result registers the same edge; back-to-back throughput is 1/cycle at LATENCY=1.
- Word index = in_alu[ADDR_W+1:2]; upper address bits ignored (wraps modulo ADDR_L words).
- Alignment: half faults if addr[0]; word faults if addr[1:0]!=0; byte never faults. Memop 11 counts as a fault. Fault: no memory write, out_fault=1, out_regwrite=0, out_memout=0, 1-cycle latency.
- Store (little-endian lanes): byte writes lane addr[1:0] with in_store[7:0]; half writes lanes {addr[1],0..1} with in_store[15:0]; word writes all lanes. The write occurs on the edge where the result registers.
- Load: select the lane(s) as for stores. Sign-extend unless memop[2]. Word ignores memop[2].
- A load issued the cycle after a store to the same word returns the stored data (stores complete before out_valid, single outstanding op).

Test Plan:
- LATENCY=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> out_memout=0xDEADBEEF one cycle after accept, out_fault=0.
- SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080; LW @0x20 -> 0x00008000 (prior zero word).
- LH @0x02 after SW 0x8001_1234 @0x00 -> 0xFFFF8001; LH @0x03 -> out_fault=1, out_regwrite=0, memory unchanged.
- LATENCY=3: LW accepted at cycle T -> busy high T+1..T+2, in_ready=0 during ACCESS, out_valid at T+3. A non-memory op accepted right after returns at +1.
- Backpressure: out_ready=0 for 4 cycles with a result held -> out_* stable, in_ready=0, no new accepts. Release -> next entry accepted the same cycle.
- ADDR_L=64: SW @0x104 wraps to word 1; LW @0x004 returns the same data. Reset asserted during ACCESS of SW -> memory word unchanged, out_valid=0.

Source files
------------

// File: rtl/mips_stage_mem_mc_if.sv
// rtl/mips_stage_mem_mc_if.sv - EX/MEM input and MEM/WB output handshake bundle for the memory stage
interface mips_stage_mem_mc_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_alu;
    logic [31:0] in_store;
    logic [4:0]  in_regdst;
    logic        in_regwrite;
    logic        in_memread;
    logic        in_memwrite;
    logic [2:0]  in_memop;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_alu;
    logic [31:0] out_memout;
    logic [4:0]  out_regdst;
    logic        out_regwrite;
    logic        out_fault;

    modport slave (
        input  in_valid, in_instr, in_pc, in_alu, in_store, in_regdst,
               in_regwrite, in_memread, in_memwrite, in_memop, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_alu, out_memout,
               out_regdst, out_regwrite, out_fault
    );

    modport master (
        output in_valid, in_instr, in_pc, in_alu, in_store, in_regdst,
               in_regwrite, in_memread, in_memwrite, in_memop, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_alu, out_memout,
               out_regdst, out_regwrite, out_fault
    );
endinterface

// File: rtl/mips_stage_mem_mc.sv
// rtl/mips_stage_mem_mc.sv - MIPS memory stage with latency-configurable data memory and handshakes
module mips_stage_mem_mc #(
    parameter int ADDR_L  = 64,
    parameter int ADDR_W  = $clog2(ADDR_L),
    parameter int LATENCY = 1,
    parameter int WORD_W  = 32
) (
    input  logic               clock,
    input  logic               reset,
    mips_stage_mem_mc_if.slave bus,
    output logic               busy
);
    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [WORD_W-1:0]   mem [ADDR_L];

    // Operands captured at accept so a multi-cycle access is independent of the EX/MEM side
    logic [WORD_W-1:0]   lat_instr_q, lat_pc_q, lat_alu_q, lat_store_q;
    logic [4:0]          lat_regdst_q;
    logic                lat_regwrite_q, lat_memread_q, lat_memwrite_q;
    logic [2:0]          lat_memop_q;

    logic [WORD_W-1:0]   out_instr_q, out_pc_q, out_alu_q, out_memout_q;
    logic [WORD_W-1:0]   out_instr_d, out_pc_d, out_alu_d, out_memout_d;
    logic [4:0]          out_regdst_q, out_regdst_d;
    logic                out_valid_q, out_valid_d, out_regwrite_q, out_regwrite_d;
    logic                out_fault_q, out_fault_d;

    logic [WORD_W-1:0]   op_instr, op_pc, op_alu, op_store;
    logic [4:0]          op_regdst;
    logic                op_regwrite, op_memread, op_memwrite;
    logic [2:0]          op_memop;
    logic                is_mem, is_load, is_store, fault;
    logic [ADDR_W-1:0]   idx;
    logic [3:0]          be;
    logic [WORD_W-1:0]   wdata, word_rd, load_ext;
    logic [7:0]          lane_b;
    logic [15:0]         lane_h;
    logic                in_ready, accept, go_access, done, mem_we;

    // Operand source: live inputs while idle, captured copy while an access is in flight
    always_comb begin
        if (state_q == S_ACCESS) begin
            op_instr = lat_instr_q;   op_pc = lat_pc_q;   op_alu = lat_alu_q;
            op_store = lat_store_q;   op_regdst = lat_regdst_q;
            op_regwrite = lat_regwrite_q; op_memread = lat_memread_q;
            op_memwrite = lat_memwrite_q; op_memop = lat_memop_q;
        end else begin
            op_instr = bus.in_instr;  op_pc = bus.in_pc;  op_alu = bus.in_alu;
            op_store = bus.in_store;  op_regdst = bus.in_regdst;
            op_regwrite = bus.in_regwrite; op_memread = bus.in_memread;
            op_memwrite = bus.in_memwrite; op_memop = bus.in_memop;
        end
    end

    // Alignment check, byte-lane enables, store data replication and load extraction
    always_comb begin
        is_mem   = op_memread || op_memwrite;
        is_store = op_memwrite;
        is_load  = op_memread && !op_memwrite;
        fault    = 1'b0;
        if (is_mem) begin
            case (op_memop[1:0])
                2'b00:   fault = 1'b0;
                2'b01:   fault = op_alu[0];
                2'b10:   fault = (op_alu[1:0] != 2'b00);
                default: fault = 1'b1;
            endcase
        end
        idx     = op_alu[ADDR_W+1:2];
        word_rd = mem[idx];
        lane_b  = word_rd[{op_alu[1:0], 3'b000} +: 8];
        lane_h  = op_alu[1] ? word_rd[31:16] : word_rd[15:0];
        case (op_memop[1:0])
            2'b00: begin
                be       = 4'b0001 << op_alu[1:0];
                wdata    = {4{op_store[7:0]}};
                load_ext = op_memop[2] ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            end
            2'b01: begin
                be       = op_alu[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{op_store[15:0]}};
                load_ext = op_memop[2] ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            end
            default: begin
                be       = 4'b1111;
                wdata    = op_store;
                load_ext = word_rd;
            end
        endcase
    end

    // State and countdown register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: only error-free memory ops with LATENCY>1 take the ACCESS detour
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (go_access) begin
                state_d = S_ACCESS;
                cnt_d   = 3'(LATENCY - 1);
            end
            S_ACCESS: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake, result-register strobe and gated memory write enable
    always_comb begin
        in_ready  = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
        busy      = (state_q != S_IDLE);
        accept    = bus.in_valid && in_ready;
        go_access = accept && is_mem && !fault && (LATENCY > 1);
        done      = (accept && !go_access) || ((state_q == S_ACCESS) && (cnt_q == 3'd1));
        mem_we    = done && is_store && !fault && !reset;
    end

    // Capture operands on accept for the multi-cycle path
    always_ff @(posedge clock) begin
        if (accept) begin
            lat_instr_q    <= bus.in_instr;    lat_pc_q       <= bus.in_pc;
            lat_alu_q      <= bus.in_alu;      lat_store_q    <= bus.in_store;
            lat_regdst_q   <= bus.in_regdst;   lat_regwrite_q <= bus.in_regwrite;
            lat_memread_q  <= bus.in_memread;  lat_memwrite_q <= bus.in_memwrite;
            lat_memop_q    <= bus.in_memop;
        end
    end

    // Byte-enabled data memory write on the edge where the result registers
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    // MEM/WB next-state: load a new result, or drop valid once consumed
    always_comb begin
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_pc_d       = out_pc_q;
        out_alu_d      = out_alu_q;
        out_memout_d   = out_memout_q;
        out_regdst_d   = out_regdst_q;
        out_regwrite_d = out_regwrite_q;
        out_fault_d    = out_fault_q;
        if (done) begin
            out_valid_d    = 1'b1;
            out_instr_d    = op_instr;
            out_pc_d       = op_pc;
            out_alu_d      = op_alu;
            out_memout_d   = (is_load && !fault) ? load_ext : '0;
            out_regdst_d   = op_regdst;
            out_regwrite_d = op_regwrite && !fault;
            out_fault_d    = fault;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // MEM/WB register
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q  <= 1'b0; out_instr_q    <= '0; out_pc_q    <= '0;
            out_alu_q    <= '0;   out_memout_q   <= '0; out_regdst_q <= '0;
            out_regwrite_q <= 1'b0; out_fault_q  <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;  out_instr_q    <= out_instr_d;
            out_pc_q     <= out_pc_d;     out_alu_q      <= out_alu_d;
            out_memout_q <= out_memout_d; out_regdst_q   <= out_regdst_d;
            out_regwrite_q <= out_regwrite_d; out_fault_q <= out_fault_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_instr    = out_instr_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.out_alu      = out_alu_q;
    assign bus.out_memout   = out_memout_q;
    assign bus.out_regdst   = out_regdst_q;
    assign bus.out_regwrite = out_regwrite_q;
    assign bus.out_fault    = out_fault_q;
endmodule

// File: tb/tb_mips_stage_mem_mc.sv
// tb/tb_mips_stage_mem_mc.sv - directed self-checking bench for mips_stage_mem_mc at LATENCY 1 and 3
module tb_mips_stage_mem_mc;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, BAD = 3'b011;
    localparam logic [2:0] LBU = 3'b100, LHU = 3'b101;

    logic clock = 1'b0;
    logic rst1, rst3, busy1, busy3;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    mips_stage_mem_mc_if if1();
    mips_stage_mem_mc_if if3();

    mips_stage_mem_mc #(.ADDR_L(64), .LATENCY(1)) u1 (.clock(clock), .reset(rst1), .bus(if1.slave), .busy(busy1));
    mips_stage_mem_mc #(.ADDR_L(64), .LATENCY(3)) u3 (.clock(clock), .reset(rst3), .bus(if3.slave), .busy(busy3));

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic put1(input logic v, rd, wr, input logic [2:0] op, input logic [31:0] alu, st, pc);
        if1.in_valid = v;  if1.in_memread = rd; if1.in_memwrite = wr; if1.in_memop = op;
        if1.in_alu = alu;  if1.in_store = st;   if1.in_pc = pc;       if1.in_instr = ~pc;
        if1.in_regdst = pc[4:0]; if1.in_regwrite = !wr;
    endtask

    task automatic put3(input logic v, rd, wr, input logic [2:0] op, input logic [31:0] alu, st, pc);
        if3.in_valid = v;  if3.in_memread = rd; if3.in_memwrite = wr; if3.in_memop = op;
        if3.in_alu = alu;  if3.in_store = st;   if3.in_pc = pc;       if3.in_instr = ~pc;
        if3.in_regdst = pc[4:0]; if3.in_regwrite = !wr;
    endtask

    // single LATENCY=1 transaction: present, accept on the next edge, then withdraw
    task automatic op1(input logic rd, wr, input logic [2:0] op, input logic [31:0] alu, st, pc);
        put1(1'b1, rd, wr, op, alu, st, pc);
        tick();
        if1.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        put1(1'b0, 1'b0, 1'b0, LW, 32'h0, 32'h0, 32'h0);
        put3(1'b0, 1'b0, 1'b0, LW, 32'h0, 32'h0, 32'h0);
        if1.out_ready = 1'b1; if3.out_ready = 1'b1;
        rst1 = 1'b1; rst3 = 1'b1;
        tick(); tick();
        rst1 = 1'b0; rst3 = 1'b0;
        n_checks++;
        if ({if1.out_valid, if1.out_fault, if1.out_regwrite} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000", {if1.out_valid, if1.out_fault, if1.out_regwrite});
        end
        n_checks++;
        if ({if1.out_memout, if1.out_pc, if1.out_alu} !== 96'h0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {if1.out_memout, if1.out_pc, if1.out_alu});
        end
        n_checks++;
        if ({busy1, busy3, if1.in_ready, if3.in_ready, if3.out_valid} !== 5'b00110) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00110", {busy1, busy3, if1.in_ready, if3.in_ready, if3.out_valid});
        end
    endtask

    task automatic test_word;
        op1(1'b0, 1'b1, LW, 32'h10, 32'hDEADBEEF, 32'h100);
        n_checks++;
        if ({if1.out_valid, if1.out_fault, if1.out_regwrite, if1.out_memout} !== {3'b100, 32'h0}) begin
            n_fail++; $display("FAIL sw_result: got %h expected %h", {if1.out_valid, if1.out_fault, if1.out_regwrite, if1.out_memout}, {3'b100, 32'h0});
        end
        op1(1'b1, 1'b0, LW, 32'h10, 32'h0, 32'h104);
        n_checks++;
        if ({if1.out_valid, if1.out_fault, if1.out_regwrite, if1.out_memout} !== {3'b101, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL lw_result: got %h expected %h", {if1.out_valid, if1.out_fault, if1.out_regwrite, if1.out_memout}, {3'b101, 32'hDEADBEEF});
        end
        n_checks++;
        if ({if1.out_pc, if1.out_alu, if1.out_instr, if1.out_regdst} !== {32'h104, 32'h10, ~32'h104, 5'h04}) begin
            n_fail++; $display("FAIL lw_passthru: got %h expected %h", {if1.out_pc, if1.out_alu, if1.out_instr, if1.out_regdst}, {32'h104, 32'h10, ~32'h104, 5'h04});
        end
    endtask

    task automatic test_byte;
        op1(1'b0, 1'b1, LW, 32'h20, 32'h0, 32'h200);
        op1(1'b0, 1'b1, LB, 32'h21, 32'h12345680, 32'h204);
        op1(1'b1, 1'b0, LB, 32'h21, 32'h0, 32'h208);
        n_checks++;
        if (if1.out_memout !== 32'hFFFFFF80) begin
            n_fail++; $display("FAIL lb_sext: got %h expected FFFFFF80", if1.out_memout);
        end
        op1(1'b1, 1'b0, LBU, 32'h21, 32'h0, 32'h20C);
        n_checks++;
        if (if1.out_memout !== 32'h00000080) begin
            n_fail++; $display("FAIL lbu_zext: got %h expected 00000080", if1.out_memout);
        end
        op1(1'b1, 1'b0, LW, 32'h20, 32'h0, 32'h210);
        n_checks++;
        if (if1.out_memout !== 32'h00008000) begin
            n_fail++; $display("FAIL sb_lane: got %h expected 00008000", if1.out_memout);
        end
    endtask

    task automatic test_half_fault;
        op1(1'b0, 1'b1, LW, 32'h0, 32'h80011234, 32'h300);
        op1(1'b1, 1'b0, LH, 32'h2, 32'h0, 32'h304);
        n_checks++;
        if (if1.out_memout !== 32'hFFFF8001) begin
            n_fail++; $display("FAIL lh_hi: got %h expected FFFF8001", if1.out_memout);
        end
        op1(1'b1, 1'b0, LHU, 32'h2, 32'h0, 32'h308);
        n_checks++;
        if (if1.out_memout !== 32'h00008001) begin
            n_fail++; $display("FAIL lhu_hi: got %h expected 00008001", if1.out_memout);
        end
        op1(1'b1, 1'b0, LH, 32'h0, 32'h0, 32'h30C);
        n_checks++;
        if (if1.out_memout !== 32'h00001234) begin
            n_fail++; $display("FAIL lh_lo: got %h expected 00001234", if1.out_memout);
        end
        op1(1'b1, 1'b0, LH, 32'h3, 32'h0, 32'h310);
        n_checks++;
        if ({if1.out_valid, if1.out_fault, if1.out_regwrite, if1.out_memout} !== {3'b110, 32'h0}) begin
            n_fail++; $display("FAIL lh_misalign: got %h expected %h", {if1.out_valid, if1.out_fault, if1.out_regwrite, if1.out_memout}, {3'b110, 32'h0});
        end
        op1(1'b0, 1'b1, LH, 32'h3, 32'hFFFFFFFF, 32'h314);
        n_checks++;
        if (if1.out_fault !== 1'b1) begin
            n_fail++; $display("FAIL sh_misalign: got %b expected 1", if1.out_fault);
        end
        op1(1'b0, 1'b1, LW, 32'h2, 32'hFFFFFFFF, 32'h318);
        op1(1'b0, 1'b1, BAD, 32'h0, 32'hFFFFFFFF, 32'h31C);
        n_checks++;
        if (if1.out_fault !== 1'b1) begin
            n_fail++; $display("FAIL memop11: got %b expected 1", if1.out_fault);
        end
        op1(1'b0, 1'b1, LB, 32'h3, 32'h000000AB, 32'h320);
        n_checks++;
        if (if1.out_fault !== 1'b0) begin
            n_fail++; $display("FAIL sb_lane3_fault: got %b expected 0", if1.out_fault);
        end
        op1(1'b1, 1'b0, LW, 32'h0, 32'h0, 32'h324);
        n_checks++;
        if (if1.out_memout !== 32'hAB011234) begin
            n_fail++; $display("FAIL fault_no_write: got %h expected AB011234", if1.out_memout);
        end
    endtask

    task automatic test_wrap;
        op1(1'b0, 1'b1, LW, 32'h104, 32'h11112222, 32'h400);
        op1(1'b1, 1'b0, LW, 32'h004, 32'h0, 32'h404);
        n_checks++;
        if (if1.out_memout !== 32'h11112222) begin
            n_fail++; $display("FAIL addr_wrap: got %h expected 11112222", if1.out_memout);
        end
        op1(1'b1, 1'b0, LW, 32'h10, 32'h0, 32'h408);
        n_checks++;
        if (if1.out_memout !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL wrap_neighbour: got %h expected DEADBEEF", if1.out_memout);
        end
    endtask

    task automatic test_back_to_back;
        put1(1'b1, 1'b1, 1'b0, LW, 32'h10, 32'h0, 32'h500);
        tick();
        n_checks++;
        if ({if1.in_ready, if1.out_valid, if1.out_memout, if1.out_pc} !== {2'b11, 32'hDEADBEEF, 32'h500}) begin
            n_fail++; $display("FAIL b2b_first: got %h expected %h", {if1.in_ready, if1.out_valid, if1.out_memout, if1.out_pc}, {2'b11, 32'hDEADBEEF, 32'h500});
        end
        put1(1'b1, 1'b1, 1'b0, LB, 32'h21, 32'h0, 32'h504);
        tick();
        n_checks++;
        if ({if1.out_valid, if1.out_memout, if1.out_pc} !== {1'b1, 32'hFFFFFF80, 32'h504}) begin
            n_fail++; $display("FAIL b2b_second: got %h expected %h", {if1.out_valid, if1.out_memout, if1.out_pc}, {1'b1, 32'hFFFFFF80, 32'h504});
        end
        put1(1'b1, 1'b0, 1'b0, LW, 32'h55, 32'h0, 32'h508);
        tick();
        n_checks++;
        if ({if1.out_valid, if1.out_regwrite, if1.out_memout, if1.out_alu} !== {2'b11, 32'h0, 32'h55}) begin
            n_fail++; $display("FAIL b2b_alu: got %h expected %h", {if1.out_valid, if1.out_regwrite, if1.out_memout, if1.out_alu}, {2'b11, 32'h0, 32'h55});
        end
        if1.in_valid = 1'b0;
        tick();
        n_checks++;
        if (if1.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain: got %b expected 0", if1.out_valid);
        end
    endtask

    task automatic test_backpressure;
        if1.out_ready = 1'b0;
        op1(1'b1, 1'b0, LW, 32'h10, 32'h0, 32'h600);
        put1(1'b1, 1'b0, 1'b0, LW, 32'h77, 32'h0, 32'h604);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({if1.in_ready, if1.out_valid, if1.out_memout, if1.out_pc} !== {2'b01, 32'hDEADBEEF, 32'h600}) begin
                n_fail++; $display("FAIL backpressure_hold[%0d]: got %h expected %h", i, {if1.in_ready, if1.out_valid, if1.out_memout, if1.out_pc}, {2'b01, 32'hDEADBEEF, 32'h600});
            end
            tick();
        end
        if1.out_ready = 1'b1;
        #1;
        n_checks++;
        if (if1.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL release_ready: got %b expected 1", if1.in_ready);
        end
        tick();
        if1.in_valid = 1'b0;
        n_checks++;
        if ({if1.out_valid, if1.out_pc, if1.out_alu, if1.out_memout} !== {1'b1, 32'h604, 32'h77, 32'h0}) begin
            n_fail++; $display("FAIL release_accept: got %h expected %h", {if1.out_valid, if1.out_pc, if1.out_alu, if1.out_memout}, {1'b1, 32'h604, 32'h77, 32'h0});
        end
        tick();
    endtask

    task automatic test_latency;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) put3(1'b1, 1'b0, 1'b1, LW, 32'h08, 32'hCAFEF00D, 32'h700);
            else        put3(1'b1, 1'b1, 1'b0, LW, 32'h08, 32'h0, 32'h704);
            tick();
            if3.in_valid = 1'b0;
            for (int c = 1; c <= 2; c++) begin
                n_checks++;
                if ({busy3, if3.in_ready, if3.out_valid} !== 3'b100) begin
                    n_fail++; $display("FAIL l3_access[%0d.%0d]: got %b expected 100", k, c, {busy3, if3.in_ready, if3.out_valid});
                end
                tick();
            end
            n_checks++;
            if ({busy3, if3.in_ready, if3.out_valid, if3.out_fault, if3.out_memout} !== {4'b0110, (k == 0) ? 32'h0 : 32'hCAFEF00D}) begin
                n_fail++; $display("FAIL l3_done[%0d]: got %h expected %h", k, {busy3, if3.in_ready, if3.out_valid, if3.out_fault, if3.out_memout}, {4'b0110, (k == 0) ? 32'h0 : 32'hCAFEF00D});
            end
        end
        put3(1'b1, 1'b0, 1'b0, LW, 32'h99, 32'h0, 32'h708);
        tick();
        n_checks++;
        if ({busy3, if3.out_valid, if3.out_alu} !== {2'b01, 32'h99}) begin
            n_fail++; $display("FAIL l3_alu_fast: got %h expected %h", {busy3, if3.out_valid, if3.out_alu}, {2'b01, 32'h99});
        end
        put3(1'b1, 1'b1, 1'b0, LW, 32'h09, 32'h0, 32'h70C);
        tick();
        if3.in_valid = 1'b0;
        n_checks++;
        if ({busy3, if3.out_valid, if3.out_fault, if3.out_regwrite} !== 4'b0110) begin
            n_fail++; $display("FAIL l3_fault_fast: got %b expected 0110", {busy3, if3.out_valid, if3.out_fault, if3.out_regwrite});
        end
        tick();
    endtask

    task automatic test_reset_access;
        put3(1'b1, 1'b0, 1'b1, LW, 32'h08, 32'h12345678, 32'h800);
        tick();
        if3.in_valid = 1'b0;
        tick();
        rst3 = 1'b1;
        tick();
        n_checks++;
        if ({busy3, if3.out_valid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_in_access: got %b expected 00", {busy3, if3.out_valid});
        end
        rst3 = 1'b0;
        put3(1'b1, 1'b1, 1'b0, LW, 32'h08, 32'h0, 32'h804);
        tick();
        if3.in_valid = 1'b0;
        tick(); tick();
        n_checks++;
        if ({if3.out_valid, if3.out_memout} !== {1'b1, 32'hCAFEF00D}) begin
            n_fail++; $display("FAIL reset_no_write: got %h expected %h", {if3.out_valid, if3.out_memout}, {1'b1, 32'hCAFEF00D});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half_fault();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_latency();
        test_reset_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
